cic_interp_mc: RTL and testbench

CIC_INTERP_MC -- requirements
Module: cic_interp_mc

---
 rtl/cic_interp_mc.sv | 156 +++++++++++++++
 tb/tb_cic_interp_mc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interp_mc.sv
// Multi-channel CIC interpolator.
// Each channel runs an N-stage comb section at the low (gate) rate, zero-stuffs
// to the clock rate, then runs N pipelined integrators and a shift/output stage.
// A small priming FSM raises data_out_gate once the first gated sample has
// propagated to the output register.
// Optional feature macro: CIC_SAT_EN -- clamp shifted output to dw bits and
// raise a sticky sat_flag; when undefined the low dw bits are taken (wrap).
module cic_interp_mc #(
   parameter int dw    = 16,
   parameter int ex    = 5,
   parameter int order = 2,
   parameter int nchan = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [nchan*dw-1:0]   data_in,
   input  logic                  data_in_gate,
   input  logic [4:0]            shift,
   output logic [nchan*dw-1:0]   data_out,
   output logic                  data_out_gate,
   output logic                  sat_flag
);

   localparam int iw = dw + ex;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t state, state_next;
   logic [2:0] prime_cnt, prime_cnt_next;

   logic signed [iw-1:0] comb_d   [nchan][order];
   logic signed [iw-1:0] comb_in  [nchan][order];
   logic signed [iw-1:0] comb_out [nchan];
   logic signed [iw-1:0] comb_acc;
   logic signed [iw-1:0] x        [nchan];
   logic signed [iw-1:0] integ    [nchan][order];
   logic        [dw-1:0] out_val  [nchan];
   logic        [4:0]    shift_eff;

   // Shift amounts beyond the guard-bit count are limited to ex
   always_comb shift_eff = (shift > 5'(ex)) ? 5'(ex) : shift;

   // Comb cascade: each stage subtracts its delayed input from the current one
   always_comb begin
      comb_acc = '0;
      for (int ch = 0; ch < nchan; ch++) begin
         comb_acc = {{ex{data_in[ch*dw+dw-1]}}, data_in[ch*dw +: dw]};
         for (int k = 0; k < order; k++) begin
            comb_in[ch][k] = comb_acc;
            comb_acc = comb_acc - comb_d[ch][k];
         end
         comb_out[ch] = comb_acc;
      end
   end

`ifdef CIC_SAT_EN
   logic signed [iw-1:0] shifted [nchan];
   logic [nchan-1:0]     ovf;
   logic                 sat_reg;

   // Shift, detect values outside the dw-bit range and clamp them
   always_comb begin
      for (int ch = 0; ch < nchan; ch++) begin
         shifted[ch] = integ[ch][order-1] >>> shift_eff;
         ovf[ch] = !((&shifted[ch][iw-1:dw-1]) || !(|shifted[ch][iw-1:dw-1]));
         if (!ovf[ch])
            out_val[ch] = shifted[ch][dw-1:0];
         else if (shifted[ch][iw-1])
            out_val[ch] = {1'b1, {(dw-1){1'b0}}};
         else
            out_val[ch] = {1'b0, {(dw-1){1'b1}}};
      end
   end

   // Sticky saturation indicator, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sat_reg <= 1'b0;
      else if (|ovf)
         sat_reg <= 1'b1;
   end

   assign sat_flag = sat_reg;
`else
   // Shift and keep the low dw bits (two's-complement wrap)
   always_comb begin
      for (int ch = 0; ch < nchan; ch++)
         out_val[ch] = dw'(integ[ch][order-1] >>> shift_eff);
   end

   assign sat_flag = 1'b0;
`endif

   // Datapath registers: comb delays, zero-stuffed x, integrators, output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int ch = 0; ch < nchan; ch++) begin
            for (int k = 0; k < order; k++) begin
               comb_d[ch][k] <= '0;
               integ[ch][k]  <= '0;
            end
            x[ch] <= '0;
         end
         data_out <= '0;
      end else begin
         for (int ch = 0; ch < nchan; ch++) begin
            if (data_in_gate) begin
               for (int k = 0; k < order; k++)
                  comb_d[ch][k] <= comb_in[ch][k];
               x[ch] <= comb_out[ch];
            end else begin
               x[ch] <= '0;
            end
            integ[ch][0] <= integ[ch][0] + x[ch];
            for (int k = 1; k < order; k++)
               integ[ch][k] <= integ[ch][k] + integ[ch][k-1];
            data_out[ch*dw +: dw] <= out_val[ch];
         end
      end
   end

   // Priming FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         prime_cnt <= '0;
      end else begin
         state     <= state_next;
         prime_cnt <= prime_cnt_next;
      end
   end

   // Wait for the first gate, then count until its sample reaches data_out
   always_comb begin
      state_next     = state;
      prime_cnt_next = prime_cnt;
      case (state)
         IDLE: begin
            if (data_in_gate) begin
               state_next     = PRIME;
               prime_cnt_next = '0;
            end
         end
         PRIME: begin
            prime_cnt_next = prime_cnt + 3'd1;
            if (prime_cnt == 3'(order))
               state_next = RUN;
         end
         RUN: state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   assign data_out_gate = (state == RUN);

endmodule

// File: tb/tb_cic_interp_mc.sv
// Self-checking bench for cic_interp_mc.
// DUT a: order 2, two channels (DC table, mid-stream reset, random run
// against a closed-form model). DUT b: order 3, one channel (impulse).
`timescale 1ns/1ps
module tb_cic_interp_mc;

   localparam int DW = 16;
   localparam int EX = 5;
   localparam int IW = DW + EX;
   localparam int NA = 2;
   localparam int NB = 3;
   localparam int MAXE = 1024;
`ifdef CIC_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [2*DW-1:0] data_in_a, data_out_a;
   logic            gate_a, out_gate_a, sat_a;
   logic [4:0]      shift_a;
   logic [DW-1:0]   data_in_b, data_out_b;
   logic            gate_b, out_gate_b, sat_b;
   logic [4:0]      shift_b;

   cic_interp_mc #(.dw(DW), .ex(EX), .order(NA), .nchan(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .data_in(data_in_a), .data_in_gate(gate_a),
      .shift(shift_a), .data_out(data_out_a), .data_out_gate(out_gate_a),
      .sat_flag(sat_a));

   cic_interp_mc #(.dw(DW), .ex(EX), .order(NB), .nchan(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .data_in(data_in_b), .data_in_gate(gate_b),
      .shift(shift_b), .data_out(data_out_b), .data_out_gate(out_gate_b),
      .sat_flag(sat_b));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state for DUT a (indices relative to last reset release)
   longint xh [2][MAXE];
   longint gh [2][MAXE];
   int     ecount, gcount, first_gate;
   longint exp_out [2];
   bit     exp_gate, exp_sat;

   typedef struct {
      int rate; int d0; int d1; int sh; int e0; int e1; bit ov;
   } dc_vec_t;

   function automatic longint binom(input longint n, input int k);
      longint r;
      if (n < 0 || n < k) return 0;
      r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   function automatic longint wrapw(input longint v, input int w);
      longint t;
      t = v <<< (64 - w);
      return t >>> (64 - w);
   endfunction

   task automatic model_reset();
      ecount = 0; gcount = 0; first_gate = -1; exp_sat = 1'b0; exp_gate = 1'b0;
   endtask

   // Closed form: comb output is the N-th difference of gate samples; N
   // cascaded pipelined accumulators weight an x sample at edge n by
   // C(t-n-1, N-1) in the accumulator value after edge t.
   task automatic model_step(input bit g, input longint d0, input longint d1, input int sh);
      longint dv [2];
      longint acc, iv, v, sgn, lim_hi, lim_lo;
      int idx;
      dv[0] = d0; dv[1] = d1;
      lim_hi = (64'sd1 <<< (DW-1)) - 1;
      lim_lo = -(64'sd1 <<< (DW-1));
      for (int ch = 0; ch < 2; ch++) begin
         if (g) begin
            gh[ch][gcount] = dv[ch];
            acc = 0;
            for (int j = 0; j <= NA; j++) begin
               idx = gcount - j;
               sgn = (j % 2) ? -1 : 1;
               if (idx >= 0) acc += sgn * binom(NA, j) * gh[ch][idx];
            end
            xh[ch][ecount] = wrapw(acc, IW);
         end else begin
            xh[ch][ecount] = 0;
         end
         iv = 0;
         for (int n = 0; n <= ecount - 2; n++) iv += xh[ch][n] * binom(ecount - 2 - n, NA - 1);
         iv = wrapw(iv, IW);
         v = iv >>> ((sh > EX) ? EX : sh);
         if (SAT_EN && v > lim_hi) begin
            exp_out[ch] = lim_hi; exp_sat = 1'b1;
         end else if (SAT_EN && v < lim_lo) begin
            exp_out[ch] = lim_lo; exp_sat = 1'b1;
         end else begin
            exp_out[ch] = wrapw(v, DW);
         end
      end
      if (g) begin
         if (first_gate < 0) first_gate = ecount;
         gcount++;
      end
      exp_gate = (first_gate >= 0) && (ecount >= first_gate + NA + 1);
      ecount++;
   endtask

   task automatic check_output(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle on DUT a, advance the model, optionally compare at edge+1
   task automatic apply_stimulus(input bit g, input int d0, input int d1, input int sh, input bit chk);
      gate_a    = g;
      data_in_a = {DW'(d1), DW'(d0)};
      shift_a   = 5'(sh);
      @(posedge clk);
      model_step(g, d0, d1, sh);
      #1;
      if (chk) begin
         check_output("model_ch0", longint'($signed(data_out_a[DW-1:0])), exp_out[0]);
         check_output("model_ch1", longint'($signed(data_out_a[2*DW-1:DW])), exp_out[1]);
         check_output("model_gate", longint'(out_gate_a), longint'(exp_gate));
         check_output("model_sat", longint'(sat_a), longint'(exp_sat));
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      gate_a = 1'b0; gate_b = 1'b0;
      data_in_a = '0; data_in_b = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      dc_vec_t vecs [7];
      int imp [10];
      int d0, d1, sh;
      bit g;

      vecs[0] = '{5, 1000, -1000, 0, 5000, -5000, 1'b0};
      vecs[1] = '{1, 100, 0, 0, 100, 0, 1'b0};
      vecs[2] = SAT_EN ? '{5, 30000, -30000, 0, 32767, -32768, 1'b1}
                       : '{5, 30000, -30000, 0, 18928, -18928, 1'b1};
      vecs[3] = '{4, 800, -3, 2, 800, -3, 1'b0};
      vecs[4] = '{8, 1000, -1000, 7, 250, -250, 1'b0};
      vecs[5] = '{3, -1001, 7, 1, -1502, 10, 1'b0};
      vecs[6] = SAT_EN ? '{2, 32767, -32768, 0, 32767, -32768, 1'b1}
                       : '{2, 32767, -32768, 0, -2, 0, 1'b1};
      imp = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

      rst_n = 1'b0;
      gate_a = 1'b0; gate_b = 1'b0;
      data_in_a = '0; data_in_b = '0;
      shift_a = '0; shift_b = '0;
      #2;
      check_output("reset_out_a", longint'(data_out_a), 0);
      check_output("reset_gate_a", longint'(out_gate_a), 0);
      check_output("reset_sat_a", longint'(sat_a), 0);
      check_output("reset_out_b", longint'(data_out_b), 0);

      // Table of DC steady-state cases
      foreach (vecs[r]) begin
         reset_dut();
         for (int c = 0; c < 12 * vecs[r].rate; c++)
            apply_stimulus(c % vecs[r].rate == 0, vecs[r].d0, vecs[r].d1, vecs[r].sh, 1'b0);
         for (int c = 0; c < 2 * vecs[r].rate; c++) begin
            apply_stimulus(c % vecs[r].rate == 0, vecs[r].d0, vecs[r].d1, vecs[r].sh, 1'b0);
            check_output($sformatf("dc%0d_ch0", r), longint'($signed(data_out_a[DW-1:0])), vecs[r].e0);
            check_output($sformatf("dc%0d_ch1", r), longint'($signed(data_out_a[2*DW-1:DW])), vecs[r].e1);
         end
         check_output($sformatf("dc%0d_gate", r), longint'(out_gate_a), 1);
         check_output($sformatf("dc%0d_sat", r), longint'(sat_a), longint'(SAT_EN && vecs[r].ov));
      end

      // Impulse through order-3 channel, gate every 4 clocks
      reset_dut();
      for (int c = 0; c < 20; c++) begin
         gate_b    = (c % 4 == 0);
         data_in_b = (c == 0) ? DW'(1) : DW'(0);
         @(posedge clk);
         #1;
         if (c >= 4)
            check_output($sformatf("imp_%0d", c),
                         longint'($signed(data_out_b)), (c - 4 < 10) ? imp[c-4] : 0);
         if (c == 3) check_output("imp_gate_low", longint'(out_gate_b), 0);
         if (c == 4) check_output("imp_gate_high", longint'(out_gate_b), 1);
      end
      gate_b = 1'b0;
      check_output("imp_sat", longint'(sat_b), 0);

      // Reset in the middle of a DC stream, then re-prime
      reset_dut();
      for (int c = 0; c < 30; c++) apply_stimulus(c % 5 == 0, 1000, -1000, 0, 1'b1);
      gate_a = 1'b1;
      rst_n  = 1'b0;
      #1;
      check_output("midrst_out", longint'(data_out_a), 0);
      check_output("midrst_gate", longint'(out_gate_a), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 3; c++) apply_stimulus(1'b0, 1000, -1000, 0, 1'b1);
      for (int c = 0; c < 30; c++) apply_stimulus(c % 5 == 0, 1000, -1000, 0, 1'b1);

      // Random gates, data and shift against the closed-form model
      reset_dut();
      sh = 0;
      for (int c = 0; c < 400; c++) begin
         if (c % 50 == 0) sh = int'($urandom_range(0, 15));
         g  = ($urandom_range(0, 3) == 0) || (c >= 200 && c < 230);
         d0 = int'($urandom_range(0, 65535)) - 32768;
         d1 = int'($urandom_range(0, 4000)) - 2000;
         apply_stimulus(g, d0, d1, sh, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
